pe_inst_sequencer: RTL and testbench

Issues PE instructions, together with aligned operand-buffer reads, to the processing-element array. It accepts one command per valid/ready handshake. A MAC command expands into a burst of N back-to-back MAC instructions with incrementing vector and matrix buffer addresses. Every other opcode issues exactly once. The block sits between the top-level controller and the PE array/operand buffers; buffer read data arrives one cycle after the read address, which matches the PE's one-cycle instruction register.

---
 rtl/pe_inst_sequencer_pkg.sv | 35 +++
 rtl/pe_inst_sequencer_addr_gen.sv | 36 +++
 rtl/pe_inst_sequencer.sv | 146 ++++++++++++++
 tb/tb_pe_inst_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_inst_sequencer_pkg.sv
// Shared PE instruction format, opcode/value/mode encodings and sequencer state type.
package pe_inst_sequencer_pkg;

  localparam logic [1:0] PE_ALU_OPCODE = 2'd0;
  localparam logic [1:0] PE_RND_OPCODE = 2'd1;

  localparam logic [3:0] PE_MAC_VALUE  = 4'd1;
  localparam logic [3:0] PE_OUT_VALUE  = 4'd2;
  localparam logic [3:0] PE_PASS_VALUE = 4'd3;
  localparam logic [3:0] PE_CLR_VALUE  = 4'd4;

  localparam logic [1:0] PE_MODE_ACC  = 2'd0;
  localparam logic [1:0] PE_MODE_LOAD = 2'd1;

  typedef struct packed {
    logic [1:0] opcode;
    logic [3:0] value;
    logic [1:0] mode;
  } pe_inst_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } seq_state_t;

  function automatic logic inst_is_mac(input pe_inst_t inst);
    return (inst.opcode == PE_ALU_OPCODE) && (inst.value == PE_MAC_VALUE);
  endfunction

  function automatic logic inst_is_pass(input pe_inst_t inst);
    return (inst.opcode == PE_ALU_OPCODE) && (inst.value == PE_PASS_VALUE);
  endfunction

endpackage

// File: rtl/pe_inst_sequencer_addr_gen.sv
// Operand buffer read-address generator: loads a base, steps by one per issued beat.
module seq_addr_gen #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = base_i;
    end else if (advance_i) begin
      // Natural overflow gives the modulo-2^ADDR_W wrap.
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/pe_inst_sequencer.sv
// Expands controller commands into PE instruction beats with aligned operand buffer reads.
module pe_inst_sequencer
  import pe_inst_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  pe_inst_t          cmd_inst,
  input  logic [ADDR_W-1:0] cmd_vec_addr,
  input  logic [ADDR_W-1:0] cmd_mat_addr,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              stall,
  output pe_inst_t          pe_inst,
  output logic              pe_inst_valid,
  output logic              vec_rd_en,
  output logic [ADDR_W-1:0] vec_rd_addr,
  output logic              mat_rd_en,
  output logic [ADDR_W-1:0] mat_rd_addr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 2);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DW-1:0]    drain_q, drain_d;
  pe_inst_t         inst_q;
  logic             valid_q, valid_d;
  logic             vrd_q, vrd_d;
  logic             mrd_q, mrd_d;
  logic             done_q, done_d;
  logic             ready_en_q;
  logic             load, advance, inst_ld;

  // Beat outputs are registered one edge ahead: the decision taken in a cycle
  // (handshake or stall) shows up on the PE interface in the following cycle.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    drain_d = drain_q;
    valid_d = 1'b0;
    vrd_d   = 1'b0;
    mrd_d   = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    inst_ld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          load = 1'b1;
          if (inst_is_mac(cmd_inst) && (cmd_count == '0)) begin
            // Empty burst still spends the nominal issue slot before draining.
            state_d = DRAIN;
            drain_d = DW'(DRAIN_CYCLES);
          end else begin
            state_d = ISSUE;
            inst_ld = 1'b1;
            valid_d = 1'b1;
            vrd_d   = inst_is_mac(cmd_inst) || inst_is_pass(cmd_inst);
            mrd_d   = inst_is_mac(cmd_inst);
            rem_d   = inst_is_mac(cmd_inst) ? cmd_count - 1'b1 : '0;
          end
        end
      end
      ISSUE: begin
        if (rem_q == '0) begin
          state_d = DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else if (!stall) begin
          advance = 1'b1;
          valid_d = 1'b1;
          vrd_d   = 1'b1;
          mrd_d   = 1'b1;
          rem_d   = rem_q - 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DRAIN) && (drain_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      drain_q    <= '0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
      vrd_q      <= 1'b0;
      mrd_q      <= 1'b0;
      done_q     <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      drain_q    <= drain_d;
      inst_q     <= inst_ld ? cmd_inst : inst_q;
      valid_q    <= valid_d;
      vrd_q      <= vrd_d;
      mrd_q      <= mrd_d;
      done_q     <= done_d;
      ready_en_q <= 1'b1;
    end
  end

  seq_addr_gen #(.ADDR_W(ADDR_W)) u_vec_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .base_i    (cmd_vec_addr),
    .advance_i (advance),
    .addr_o    (vec_rd_addr)
  );

  seq_addr_gen #(.ADDR_W(ADDR_W)) u_mat_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .base_i    (cmd_mat_addr),
    .advance_i (advance),
    .addr_o    (mat_rd_addr)
  );

  // ready_en_q keeps cmd_ready low while reset is held.
  assign cmd_ready     = (state_q == IDLE) && ready_en_q;
  assign busy          = (state_q != IDLE);
  assign pe_inst       = inst_q;
  assign pe_inst_valid = valid_q;
  assign vec_rd_en     = vrd_q;
  assign mat_rd_en     = mrd_q;
  assign done          = done_q;

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// Directed self-checking bench for pe_inst_sequencer (ADDR_W=10, CNT_W=8, DRAIN_CYCLES=2).
module tb_pe_inst_sequencer;
  import pe_inst_sequencer_pkg::*;

  localparam int unsigned ADDR_W       = 10;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned DRAIN_CYCLES = 2;

  localparam pe_inst_t MAC_I  = '{opcode: PE_ALU_OPCODE, value: PE_MAC_VALUE,  mode: PE_MODE_ACC};
  localparam pe_inst_t PASS_I = '{opcode: PE_ALU_OPCODE, value: PE_PASS_VALUE, mode: PE_MODE_LOAD};
  localparam pe_inst_t OUT_I  = '{opcode: PE_ALU_OPCODE, value: PE_OUT_VALUE,  mode: PE_MODE_ACC};
  localparam pe_inst_t CLR_I  = '{opcode: PE_ALU_OPCODE, value: PE_CLR_VALUE,  mode: PE_MODE_ACC};
  localparam pe_inst_t RND_I  = '{opcode: PE_RND_OPCODE, value: 4'd9,          mode: PE_MODE_LOAD};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  pe_inst_t          cmd_inst;
  logic [ADDR_W-1:0] cmd_vec_addr;
  logic [ADDR_W-1:0] cmd_mat_addr;
  logic [CNT_W-1:0]  cmd_count;
  logic              stall;
  pe_inst_t          pe_inst;
  logic              pe_inst_valid;
  logic              vec_rd_en;
  logic [ADDR_W-1:0] vec_rd_addr;
  logic              mat_rd_en;
  logic [ADDR_W-1:0] mat_rd_addr;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  logic [5:0] obs;
  assign obs = {pe_inst_valid, vec_rd_en, mat_rd_en, done, cmd_ready, busy};

  always #5 clk = ~clk;

  pe_inst_sequencer #(
    .ADDR_W       (ADDR_W),
    .CNT_W        (CNT_W),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_inst      (cmd_inst),
    .cmd_vec_addr  (cmd_vec_addr),
    .cmd_mat_addr  (cmd_mat_addr),
    .cmd_count     (cmd_count),
    .stall         (stall),
    .pe_inst       (pe_inst),
    .pe_inst_valid (pe_inst_valid),
    .vec_rd_en     (vec_rd_en),
    .vec_rd_addr   (vec_rd_addr),
    .mat_rd_en     (mat_rd_en),
    .mat_rd_addr   (mat_rd_addr),
    .busy          (busy),
    .done          (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command for the current cycle, then scrambles the command bus.
  task automatic send(input pe_inst_t inst, input logic [ADDR_W-1:0] va,
                      input logic [ADDR_W-1:0] ma, input logic [CNT_W-1:0] cnt);
    cmd_valid    = 1'b1;
    cmd_inst     = inst;
    cmd_vec_addr = va;
    cmd_mat_addr = ma;
    cmd_count    = cnt;
    tick();
    cmd_valid       = 1'b0;
    cmd_inst.opcode = 2'($urandom);
    cmd_inst.value  = 4'($urandom);
    cmd_inst.mode   = 2'($urandom);
    cmd_vec_addr    = ADDR_W'($urandom);
    cmd_mat_addr    = ADDR_W'($urandom);
    cmd_count       = CNT_W'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_inst = '0; stall = 1'b0;
    cmd_vec_addr = '0; cmd_mat_addr = '0; cmd_count = '0;
    #12;
    checks++;
    if (obs !== 6'b0 || pe_inst !== '0 || vec_rd_addr !== '0 || mat_rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got flags=%b inst=%h va=%h ma=%h want all 0",
               obs, pe_inst, vec_rd_addr, mat_rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 6'b000010) begin
      errors++;
      $display("FAIL reset_release: got flags=%b want 000010", obs);
    end
  endtask

  task automatic test_mac_burst();
    logic [5:0] exp;
    send(MAC_I, 10'h010, 10'h200, 8'd4);
    for (int c = 1; c <= 7; c++) begin
      exp = {c <= 4, c <= 4, c <= 4, c == 6, c >= 7, c <= 6};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mac_burst_flags c%0d: got %b want %b", c, obs, exp);
      end
      if (c <= 4) begin
        checks++;
        if (vec_rd_addr !== 10'h010 + ADDR_W'(c - 1) || mat_rd_addr !== 10'h200 + ADDR_W'(c - 1)
            || pe_inst !== MAC_I) begin
          errors++;
          $display("FAIL mac_burst_addr c%0d: got va=%h ma=%h inst=%h want va=%h ma=%h inst=%h",
                   c, vec_rd_addr, mat_rd_addr, pe_inst,
                   10'h010 + ADDR_W'(c - 1), 10'h200 + ADDR_W'(c - 1), MAC_I);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [5:0] exp;
    int unsigned off[6] = '{0, 1, 1, 1, 2, 3};
    logic        vld[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int          beats  = 0;
    send(MAC_I, 10'h010, 10'h200, 8'd4);
    for (int c = 1; c <= 9; c++) begin
      stall = (c == 2) || (c == 3) || (c == 7);
      exp = {vld[c-1], vld[c-1], vld[c-1], c == 8, c >= 9, c <= 8};
      beats += int'(pe_inst_valid);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stall_flags c%0d: got %b want %b", c, obs, exp);
      end
      if (c <= 6) begin
        checks++;
        if (vec_rd_addr !== 10'h010 + ADDR_W'(off[c-1]) || mat_rd_addr !== 10'h200 + ADDR_W'(off[c-1])) begin
          errors++;
          $display("FAIL stall_addr c%0d: got va=%h ma=%h want va=%h ma=%h", c, vec_rd_addr,
                   mat_rd_addr, 10'h010 + ADDR_W'(off[c-1]), 10'h200 + ADDR_W'(off[c-1]));
        end
      end
      tick();
    end
    stall = 1'b0;
    checks++;
    if (beats != 4) begin
      errors++;
      $display("FAIL stall_beats: got %0d want 4", beats);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    pe_inst_t   insts[4] = '{PASS_I, OUT_I, CLR_I, RND_I};
    int         dones    = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready cmd%0d: got %b want 1", i, cmd_ready);
      end
      send(insts[i], 10'h055 + ADDR_W'(i), 10'h123, 8'd7);
      for (int c = 1; c <= 3; c++) begin
        exp = {c == 1, (c == 1) && (i == 0), 1'b0, c == 3, 1'b0, 1'b1};
        dones += int'(done);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL b2b_flags cmd%0d c%0d: got %b want %b", i, c, obs, exp);
        end
        if (c == 1) begin
          checks++;
          if (pe_inst !== insts[i] || (i == 0 && vec_rd_addr !== 10'h055)) begin
            errors++;
            $display("FAIL b2b_inst cmd%0d: got inst=%h va=%h want inst=%h va=055",
                     i, pe_inst, vec_rd_addr, insts[i]);
          end
        end
        tick();
      end
    end
    checks++;
    if (dones != 4) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d want 4", dones);
    end
  endtask

  task automatic test_mac_zero();
    logic [5:0] exp;
    send(MAC_I, 10'h0AA, 10'h0BB, 8'd0);
    for (int c = 1; c <= 4; c++) begin
      exp = {1'b0, 1'b0, 1'b0, c == 3, c == 4, c <= 3};
      checks++;
      if (obs !== exp || pe_inst !== RND_I) begin
        errors++;
        $display("FAIL mac_zero c%0d: got flags=%b inst=%h want flags=%b inst=%h",
                 c, obs, pe_inst, exp, RND_I);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [5:0]        exp;
    logic [ADDR_W-1:0] va_exp[3] = '{10'h3FF, 10'h000, 10'h001};
    logic [ADDR_W-1:0] ma_exp[3] = '{10'h3FE, 10'h3FF, 10'h000};
    send(MAC_I, 10'h3FF, 10'h3FE, 8'd3);
    for (int c = 1; c <= 6; c++) begin
      exp = {c <= 3, c <= 3, c <= 3, c == 5, c == 6, c <= 5};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL wrap_flags c%0d: got %b want %b", c, obs, exp);
      end
      if (c <= 3) begin
        checks++;
        if (vec_rd_addr !== va_exp[c-1] || mat_rd_addr !== ma_exp[c-1]) begin
          errors++;
          $display("FAIL wrap_addr c%0d: got va=%h ma=%h want va=%h ma=%h",
                   c, vec_rd_addr, mat_rd_addr, va_exp[c-1], ma_exp[c-1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    send(MAC_I, 10'h100, 10'h080, 8'd8);
    tick();
    checks++;
    if (pe_inst_valid !== 1'b1 || vec_rd_addr !== 10'h101) begin
      errors++;
      $display("FAIL rstmid_beat2: got valid=%b va=%h want valid=1 va=101", pe_inst_valid, vec_rd_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b0 || pe_inst !== '0 || vec_rd_addr !== '0 || mat_rd_addr !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got flags=%b inst=%h va=%h ma=%h want all 0",
               obs, pe_inst, vec_rd_addr, mat_rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 6'b000010) begin
      errors++;
      $display("FAIL rstmid_release: got flags=%b want 000010", obs);
    end
    for (int c = 0; c < 12; c++) begin
      seen |= done | pe_inst_valid;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_done: got activity=%b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_mac_burst();
    test_stall();
    test_back_to_back();
    test_mac_zero();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
